// File: rtl/alu_dmem_unit.sv
// ---------------------------------------------------------------------------
// alu_dmem_unit
//   Datapath slice: ALU control decoder, combinational 32-bit ALU with status
//   flags, and a 64 x 32 data memory that reads combinationally and writes
//   synchronously.
//
// Ports
//   clk                 rising-edge clock
//   reset               asynchronous active-low reset. It clears the data
//                       memory and blocks writes while low.
//   ALUop[1:0]          operation class from main control
//   funct[5:0]          R-type function field
//   shamt[4:0]          shift amount
//   src_a, src_b        ALU operands
//   ALU_control_signal  decoded 4-bit ALU operation (1111 = invalid)
//   ALU_result          ALU result
//   ALU_status[7:0]     {zero, overflow, carry/borrow, negative, invalid, 000}
//   DMEM_address        byte address. Word index is bits [7:2].
//   DMEM_data_in        store data
//   DMEM_mem_write      write enable, sampled on the rising clk edge
//   DMEM_mem_read       read enable. The output is 0 when this is low.
//   DMEM_data_out       load data (combinational)
// ---------------------------------------------------------------------------
module alu_dmem_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        ALUop,
  input  logic [5:0]        funct,
  input  logic [4:0]        shamt,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic [3:0]        ALU_control_signal,
  output logic [DATA_W-1:0] ALU_result,
  output logic [7:0]        ALU_status,
  input  logic [31:0]       DMEM_address,
  input  logic [DATA_W-1:0] DMEM_data_in,
  input  logic              DMEM_mem_write,
  input  logic              DMEM_mem_read,
  output logic [DATA_W-1:0] DMEM_data_out
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_INV = 4'b1111;

  localparam int DEPTH = 64;

  // ---------------- ALU control decode ----------------
  logic [3:0] ctrl;

  always_comb begin
    ctrl = OP_INV;
    case (ALUop)
      2'b00: ctrl = OP_ADD;
      2'b01: ctrl = OP_SUB;
      2'b11: ctrl = OP_SLT;
      default: begin
        case (funct)
          6'b100000, 6'b100001: ctrl = OP_ADD;
          6'b100010, 6'b100011: ctrl = OP_SUB;
          6'b100100:            ctrl = OP_AND;
          6'b100101:            ctrl = OP_OR;
          6'b100110:            ctrl = OP_XOR;
          6'b100111:            ctrl = OP_NOR;
          6'b101010:            ctrl = OP_SLT;
          6'b000000:            ctrl = OP_SLL;
          6'b000010:            ctrl = OP_SRL;
          6'b000011:            ctrl = OP_SRA;
          default:              ctrl = OP_INV;
        endcase
      end
    endcase
  end

  assign ALU_control_signal = ctrl;

  // ---------------- ALU datapath ----------------
  logic signed [DATA_W-1:0] a_s;
  logic signed [DATA_W-1:0] b_s;
  logic        [DATA_W:0]   add_ext;
  logic        [DATA_W-1:0] sub_res;
  logic        [DATA_W-1:0] res;
  logic                     ovf;
  logic                     cry;

  assign a_s     = $signed(src_a);
  assign b_s     = $signed(src_b);
  assign add_ext = {1'b0, src_a} + {1'b0, src_b};
  assign sub_res = src_a - src_b;

  always_comb begin
    res = '0;
    ovf = 1'b0;
    cry = 1'b0;
    case (ctrl)
      OP_ADD: begin
        res = add_ext[DATA_W-1:0];
        cry = add_ext[DATA_W];
        ovf = (src_a[DATA_W-1] == src_b[DATA_W-1]) &&
              (res[DATA_W-1] != src_a[DATA_W-1]);
      end
      OP_SUB: begin
        res = sub_res;
        // The borrow flag is the unsigned "a < b" comparison.
        cry = (src_a < src_b);
        ovf = (src_a[DATA_W-1] != src_b[DATA_W-1]) &&
              (res[DATA_W-1] != src_a[DATA_W-1]);
      end
      OP_AND: res = src_a & src_b;
      OP_OR:  res = src_a | src_b;
      OP_XOR: res = src_a ^ src_b;
      OP_NOR: res = ~(src_a | src_b);
      OP_SLT: res = {{(DATA_W-1){1'b0}}, (a_s < b_s)};
      // Shifts operate on src_b only. src_a is the unused rs field.
      OP_SLL: res = src_b << shamt;
      OP_SRL: res = src_b >> shamt;
      OP_SRA: res = $unsigned(b_s >>> shamt);
      default: res = '0;
    endcase
  end

  assign ALU_result = res;
  assign ALU_status = {(res == '0), ovf, cry, res[DATA_W-1], (ctrl == OP_INV), 3'b000};

  // ---------------- data memory ----------------
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [5:0]        widx;

  // Bits [31:8] and [1:0] are dropped, so addresses wrap every 256 bytes.
  assign widx = DMEM_address[7:2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (DMEM_mem_write) begin
      mem_q[widx] <= DMEM_data_in;
    end
  end

  // A read of the word being written returns the old contents until the edge.
  assign DMEM_data_out = DMEM_mem_read ? mem_q[widx] : '0;

endmodule

// File: tb/tb_alu_dmem_unit.sv
module tb_alu_dmem_unit;

  logic        clk;
  logic        reset;
  logic [1:0]  ALUop;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [3:0]  ALU_control_signal;
  logic [31:0] ALU_result;
  logic [7:0]  ALU_status;
  logic [31:0] DMEM_address;
  logic [31:0] DMEM_data_in;
  logic        DMEM_mem_write;
  logic        DMEM_mem_read;
  logic [31:0] DMEM_data_out;

  int n_cmp = 0;
  int n_err = 0;

  alu_dmem_unit dut (
    .clk                (clk),
    .reset              (reset),
    .ALUop              (ALUop),
    .funct              (funct),
    .shamt              (shamt),
    .src_a              (src_a),
    .src_b              (src_b),
    .ALU_control_signal (ALU_control_signal),
    .ALU_result         (ALU_result),
    .ALU_status         (ALU_status),
    .DMEM_address       (DMEM_address),
    .DMEM_data_in       (DMEM_data_in),
    .DMEM_mem_write     (DMEM_mem_write),
    .DMEM_mem_read      (DMEM_mem_read),
    .DMEM_data_out      (DMEM_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic alu_vec(input string tag, input logic [1:0] op, input logic [5:0] fn,
                         input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] e_ctl, input logic [31:0] e_res, input logic [7:0] e_st);
    ALUop = op; funct = fn; shamt = sh; src_a = a; src_b = b;
    #1;
    check_eq({tag, ".ctl"}, {28'd0, ALU_control_signal}, {28'd0, e_ctl});
    check_eq({tag, ".res"}, ALU_result, e_res);
    check_eq({tag, ".st"},  {24'd0, ALU_status}, {24'd0, e_st});
  endtask

  // Set up a write at the falling edge, let one rising edge pass, then drop write enable.
  task automatic mem_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    DMEM_address = addr; DMEM_data_in = data; DMEM_mem_write = 1'b1;
    @(posedge clk); #1;
    DMEM_mem_write = 1'b0;
  endtask

  task automatic mem_read(input string tag, input logic [31:0] addr, input logic rd,
                          input logic [31:0] exp);
    DMEM_address = addr; DMEM_mem_read = rd;
    #1;
    check_eq(tag, DMEM_data_out, exp);
  endtask

  initial begin
    reset = 1'b0;
    ALUop = 2'b00; funct = 6'd0; shamt = 5'd0; src_a = 32'd0; src_b = 32'd0;
    DMEM_address = 32'd0; DMEM_data_in = 32'd0; DMEM_mem_write = 1'b0; DMEM_mem_read = 1'b0;
    #2;

    // Reset state: memory is cleared. Also, the ALU is live during reset.
    mem_read("rst.mem10", 32'h10, 1'b1, 32'h0);
    alu_vec("rst.add", 2'b00, 6'd0, 5'd0, 32'd3, 32'd4, 4'h2, 32'd7, 8'h00);

    // ALU vectors
    alu_vec("add.ovf",  2'b10, 6'h20, 5'd0, 32'h7FFFFFFF, 32'h1,        4'h2, 32'h80000000, 8'h50);
    alu_vec("sub.zero", 2'b01, 6'h00, 5'd0, 32'd5,        32'd5,        4'h6, 32'h0,        8'h80);
    alu_vec("sra",      2'b10, 6'h03, 5'd4, 32'h0,        32'hF0000000, 4'hA, 32'hFF000000, 8'h10);
    alu_vec("slt.neg",  2'b10, 6'h2A, 5'd0, 32'hFFFFFFFF, 32'h1,        4'h7, 32'h1,        8'h00);
    alu_vec("invalid",  2'b10, 6'h3F, 5'd0, 32'h1234,     32'h5678,     4'hF, 32'h0,        8'h88);
    alu_vec("add.cry",  2'b00, 6'h00, 5'd0, 32'hFFFFFFFF, 32'h1,        4'h2, 32'h0,        8'hA0);
    alu_vec("sub.brw",  2'b01, 6'h00, 5'd0, 32'h1,        32'h2,        4'h6, 32'hFFFFFFFF, 8'h30);
    alu_vec("sub.ovf",  2'b01, 6'h00, 5'd0, 32'h80000000, 32'h1,        4'h6, 32'h7FFFFFFF, 8'h40);
    alu_vec("nor",      2'b10, 6'h27, 5'd0, 32'h0,        32'h0,        4'hC, 32'hFFFFFFFF, 8'h10);
    alu_vec("sll.0",    2'b10, 6'h00, 5'd0, 32'hAAAAAAAA, 32'h12345678, 4'h8, 32'h12345678, 8'h00);
    alu_vec("sll.8",    2'b10, 6'h00, 5'd8, 32'h0,        32'h12345678, 4'h8, 32'h34567800, 8'h00);
    alu_vec("srl",      2'b10, 6'h02, 5'd4, 32'h0,        32'hF0000000, 4'h9, 32'h0F000000, 8'h00);
    alu_vec("slt.op11", 2'b11, 6'h00, 5'd0, 32'h1,        32'hFFFFFFFF, 4'h7, 32'h0,        8'h80);
    alu_vec("and",      2'b10, 6'h24, 5'd0, 32'hF0F0,     32'hFF00,     4'h0, 32'hF000,     8'h00);
    alu_vec("or",       2'b10, 6'h25, 5'd0, 32'hF0F0,     32'hFF00,     4'h1, 32'hFFF0,     8'h00);
    alu_vec("xor",      2'b10, 6'h26, 5'd0, 32'hF0F0,     32'hFF00,     4'h3, 32'h0FF0,     8'h00);
    alu_vec("addu",     2'b10, 6'h21, 5'd0, 32'd10,       32'd20,       4'h2, 32'd30,       8'h00);
    alu_vec("subu",     2'b10, 6'h23, 5'd0, 32'd10,       32'd20,       4'h6, 32'hFFFFFFF6, 8'h30);

    // Release reset away from the rising edge.
    @(negedge clk);
    reset = 1'b1;

    // Read-during-write: the old contents are visible before the edge.
    @(negedge clk);
    DMEM_address = 32'h10; DMEM_data_in = 32'hDEADBEEF; DMEM_mem_write = 1'b1; DMEM_mem_read = 1'b1;
    #1;
    check_eq("rdw.old", DMEM_data_out, 32'h0);
    @(posedge clk); #1;
    DMEM_mem_write = 1'b0;
    mem_read("wr.10",   32'h10,  1'b1, 32'hDEADBEEF);
    mem_read("wr.113",  32'h113, 1'b1, 32'hDEADBEEF);
    mem_read("rd.off",  32'h10,  1'b0, 32'h0);

    mem_write(32'h14, 32'h11111111);
    mem_read("wr.14",   32'h14,  1'b1, 32'h11111111);
    mem_read("keep.10", 32'h12,  1'b1, 32'hDEADBEEF);
    mem_write(32'hFC, 32'hA5A5A5A5);
    mem_read("wr.3fc",  32'hFFFFF3FC, 1'b1, 32'hA5A5A5A5);

    // Reset pulse in mid-run. A write attempted during reset is ignored.
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    mem_read("rst2.10", 32'h10, 1'b1, 32'h0);
    mem_read("rst2.14", 32'h14, 1'b1, 32'h0);
    mem_write(32'h10, 32'hCAFEF00D);
    mem_read("rst2.blk", 32'h10, 1'b1, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    mem_read("rst2.after", 32'h10, 1'b1, 32'h0);
    mem_write(32'h10, 32'h55AA55AA);
    mem_read("resume.10", 32'h10, 1'b1, 32'h55AA55AA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
